// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: op codes, frame widths and initiator state encoding.
// The slave/RAM side imports this package as well, so both ends agree on the frame layout.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int OP_W    = 2;
  localparam int CNT_W   = 4;

  localparam logic [OP_W-1:0] OP_WR_ADDR = 2'b00;
  localparam logic [OP_W-1:0] OP_WR_DATA = 2'b01;
  localparam logic [OP_W-1:0] OP_RD_ADDR = 2'b10;
  localparam logic [OP_W-1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_DONE
  } state_e;

  // Only rd-data frames carry a turnaround and a returned byte.
  function automatic logic has_reply(input logic [OP_W-1:0] op);
    return op == OP_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Command/response port of the SPI initiator: one-cycle valid/ready command in, pulsed read byte out.
// master = local controller side, slave = spi_master side.
interface spi_master_if
  import spi_pkg::*;
;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/spi_master.sv
// SPI initiator clocked by clk itself: a command becomes a registered SS_n/MOSI frame; rd-data captures MISO.
// SS_n falls 1 cycle after accept, reply pulses 20+TURN_CYCLES cycles after accept; commands stall (cmd_ready low) while busy.
module spi_master
  import spi_pkg::*;
#(
  parameter int TURN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_master_if.slave cmd_if,
  output logic        SS_n,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);

  state_e             state, state_nxt;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               ss_n_d, mosi_d;
  logic               accept;

  assign accept = cmd_if.cmd_valid && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      SS_n        <= 1'b1;
      MOSI        <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      SS_n        <= ss_n_d;
      MOSI        <= mosi_d;
    end
  end

  // Pin values are decoded from the state being entered, so SS_n/MOSI come straight off flops.
  always_comb begin
    state_nxt   = state;
    sh_d        = sh_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          sh_d      = {cmd_if.cmd_op, cmd_if.cmd_data};
          op_d      = cmd_if.cmd_op;
          cnt_d     = '0;
          rx_d      = '0;
          ss_n_d    = 1'b0;
          mosi_d    = cmd_if.cmd_op[OP_W-1];
          state_nxt = ST_CMD;
        end
      end

      ST_CMD: begin
        ss_n_d    = 1'b0;
        mosi_d    = sh_q[FRAME_W-1];
        sh_d      = sh_q << 1;
        state_nxt = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (cnt_q != SHIFT_LAST) begin
          ss_n_d = 1'b0;
          mosi_d = sh_q[FRAME_W-1];
          sh_d   = sh_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (has_reply(op_q)) begin
            ss_n_d    = 1'b0;
            state_nxt = ST_TURN;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end

      ST_TURN: begin
        ss_n_d = 1'b0;
        if (cnt_q == TURN_LAST) begin
          cnt_d     = '0;
          state_nxt = ST_RECV;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RECV: begin
        rx_d = {rx_q[DATA_W-2:0], MISO};
        if (cnt_q == RECV_LAST) begin
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[DATA_W-2:0], MISO};
          state_nxt   = ST_DONE;
        end else begin
          ss_n_d = 1'b0;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd_if.cmd_ready = (state == ST_IDLE);
  assign cmd_if.busy      = (state != ST_IDLE);
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_data  = rsp_data_q;

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI initiator that drives the command/data frames consumed by the team's SPI slave + single-port RAM block, and collects read bytes returned on MISO. It turns one-cycle command requests (`op`, 8-bit payload) from a local controller into complete SS_n/MOSI frames. For read-data commands it also captures the 8-bit reply and presents it on a response port. SCK is not generated: the serial bit clock is `clk` itself, shared with the slave.

## Interface
- `TURN_CYCLES`, 2: SS_n-low idle cycles between the last MOSI bit of a read-data frame and the first MISO sample (≥1).
- `clk` input 1: system and serial bit clock, rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: high only in IDLE; a command is accepted on `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` input 2: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
- `cmd_data` input 8: address or write data; don't-care for op 11.
- `rsp_valid` output 1: one-cycle pulse, read byte available.
- `rsp_data` output 8: read byte; holds its value until the next read completes.
- `busy` output 1: high from acceptance until return to IDLE.
- `SS_n` output 1: slave select, active-low, registered.
- `MOSI` output 1: serial out, MSB first, registered.
- `MISO` input 1: serial in from the slave.

## Operation
- States: IDLE, CMD, SHIFT, TURN, RECV, DONE.
- IDLE:
  - SS_n=1, MOSI=0, cmd_ready=1.
  - On accept: latch `{cmd_op, cmd_data}` into a 10-bit shift register, go to CMD.
- CMD, 1 cycle: SS_n=0, MOSI=op[1]. This is the slave's command-check bit. Go to SHIFT.
- SHIFT, 10 cycles: MOSI = frame bits 9..0, MSB first. A 4-bit counter is used.
  - Then go to TURN if op==11, else DONE.
- TURN, `TURN_CYCLES` cycles: SS_n=0, MOSI=0. Go to RECV.
- RECV, 8 cycles: SS_n=0, MOSI=0.
  - MISO is shifted into an 8-bit register MSB first, one bit at each rising edge that ends a RECV cycle.
- DONE, 1 cycle: SS_n=1, cmd_ready=0.
  - For op 11: rsp_valid=1 and rsp_data = captured byte.
  - Go to IDLE.
- `cmd_valid` outside IDLE is ignored. There is no queuing, and the command is not consumed.
- No op is illegal. A rd-data issued without a prior rd-addr still runs a full frame, and the returned byte is whatever MISO carries.

## Timing
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, state IDLE, counters and shift registers 0.
- Accept at edge T0:
  - SS_n falls in cycle T0+1 (CMD).
  - MOSI bit 9 is driven in T0+2, and bit 0 in T0+11.
- Write-type and rd-addr frames:
  - DONE in T0+12, IDLE in T0+13.
  - Total SS_n-low span is 11 cycles.
- Rd-data frames:
  - TURN occupies T0+12 .. T0+11+TURN_CYCLES.
  - RECV occupies the next 8 cycles.
  - DONE, with the rsp_valid pulse, follows directly.
  - With the default parameter, rsp_valid is high in T0+22.
- Back-to-back: the earliest next accept is in the IDLE cycle. SS_n is therefore high for at least 2 cycles between frames.
- Reset mid-frame:
  - SS_n goes to 1 and MOSI to 0 immediately (asynchronous).
  - A pending rsp_valid is dropped.
  - The partial byte is discarded and rsp_data goes to 0.
- SS_n and MOSI change only on rising edges, never glitch combinationally.

## Structure
- Shared package `spi_pkg` holds:
  - op-code constants: `OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`;
  - the state encoding;
  - `FRAME_W`=10 and `DATA_W`=8.
- The slave side must import the same constants.
- Single module. The shift/bit-count logic is inline, and no sub-module is warranted.

## Test plan
- Reset, then hold idle 5 cycles → SS_n=1, MOSI=0, cmd_ready=1, rsp_valid never asserted.
- Accept op=00, data=0x5A → SS_n low for exactly 11 cycles; MOSI sequence 0, then 0,0,0,1,0,1,1,0,1,0; DONE next; no rsp_valid.
- Run op=10/0x3C then op=11 against the slave+RAM preloaded with mem[0x3C]=0xA7 → second frame: rsp_valid one cycle at T0+22, rsp_data=0xA7.
- Hold `cmd_valid` continuously with alternating ops → each accept only in IDLE; SS_n high ≥2 cycles between frames; no command lost or duplicated.
- Assert rst_n low during SHIFT bit 5 of a rd-data frame → SS_n=1 in the same cycle; no rsp_valid; the next command after release starts a clean frame.
- Rd-data with TURN_CYCLES=3 against a MISO stub driving 0x81 → first sample 3 cycles after the last MOSI bit; rsp_data=0x81.
